wb_queue_multi: RTL
===================

Name: wb_queue_multi

Overview:
- Next-generation write-back stage.
- Accepts up to LANES results per cycle from the EX/WB pipeline register and buffers them in an in-order pending queue of DEPTH entries.
- Retires up to WPORTS entries per cycle to the register-file write ports.
- Provides a forwarding lookup for pending writes, a registered result-output channel, and a back-pressure stall toward EX.

Parameters:
- LANES, 2, number of result lanes presented by EX per cycle; lane 0 is oldest.
- WPORTS, 1, number of register-file write ports; must be 1..LANES.
- DEPTH, 4, pending-queue entries; must be a power of two and >= LANES.
- DW, 8, data width.
- AW, 3, register address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- internal_reset  in  1  synchronous flush, active-high.
- ex_valid  in  LANES  lane carries a result.
- ex_wr_en  in  LANES  lane result is to be written to the register file.
- ex_dst  in  LANES*AW  per-lane destination register.
- ex_data  in  LANES*DW  per-lane result data.
- stall  out  1  EX must hold its lanes; lanes presented while stall=1 are ignored.
- rf_wr_en  out  WPORTS  per-port write enable.
- rf_dst  out  WPORTS*AW  per-port destination.
- rf_data  out  WPORTS*DW  per-port data.
- fwd_addr  in  AW  forwarding query address.
- fwd_hit  out  1  a queued entry targets fwd_addr.
- fwd_data  out  DW  data of the youngest matching queued entry.
- out_valid  out  1  result-output strobe.
- out_dst  out  AW  destination of the output result.
- out_data  out  DW  data of the output result.

Behaviour:
- Reset (rst_n=0, asynchronous): read pointer, write pointer and count go to 0. stall=0, rf_wr_en=0, out_valid=0, out_dst=0, out_data=0, fwd_hit=0.
- Enqueue:
  - When stall=0, every lane with ex_valid=1 and ex_wr_en=1 is written at the write pointer in lane order (compacted, no holes).
  - Lanes with ex_wr_en=0 are dropped.
- stall is combinational from the registered count: stall = (DEPTH - count) < LANES. It never depends on same-cycle inputs.
- Drain:
  - Each cycle the min(count, WPORTS) oldest entries present on rf ports in age order, port 0 oldest.
  - Those entries are popped at the clock edge.
  - Latency: enqueued at edge N, earliest write at cycle N+1.
  - There is no bypass from EX to the RF.
- Same-dst collision: if two entries drained in the same cycle share a dst, the older port's rf_wr_en is forced to 0.
- Count update: count_next = count - drained + enqueued. Simultaneous enqueue and drain in the same cycle is legal. Pointers wrap modulo DEPTH.
- Full: count=DEPTH implies stall=1. Drain continues, so the queue can never deadlock.
- Empty: rf_wr_en=0 on all ports.
- Forwarding:
  - fwd_hit and fwd_data are combinational over the valid queue entries only. In-flight EX lanes are not searched.
  - The youngest match wins.
  - Entries being drained in the current cycle still hit.
- Output channel:
  - Registered. At an edge where >=1 entry is drained with a non-suppressed write, out_valid=1 the next cycle and out_dst/out_data take the youngest such drained entry.
  - Otherwise out_valid=0; out_dst/out_data hold their values.
- internal_reset=1:
  - This cycle: rf_wr_en forced to 0 and enqueue suppressed.
  - Next edge: pointers and count go to 0, and out_valid goes to 0.
  - Queue contents are discarded.
  - Takes priority over all other events in that cycle.
- Async reset asserted mid-drain: outputs go to their reset values immediately, with no partial write.

Decomposition:
- Package wb_pkg holds:
  - a typedef for the queue entry struct {dst, data};
  - localparam helpers for pointer width, $clog2(DEPTH), and count width, $clog2(DEPTH+1);
  - a function for the lane-compaction index.
- One sub-module, wb_fwd_cam: DEPTH-entry address compare with youngest-match priority select, taking pointers and count as inputs.

Test Plan:
- Defaults, reset released, both lanes valid: lane0 (r1, 0x11), lane1 (r2, 0x22).
  - Next cycle: port 0 writes r1/0x11.
  - Following cycle: port 0 writes r2/0x22.
  - out_valid pulses one cycle after each write with matching dst/data.
- Lane0 ex_wr_en=0, lane1 (r5, 0x55): only r5 is enqueued; count=1; a single write occurs.
- Back-pressure with WPORTS=1, DEPTH=4: present 2 lanes every cycle.
  - stall=1 once count=3, i.e. free < 2.
  - No entry is lost or duplicated.
  - Write order exactly matches lane order across 10 cycles.
- WPORTS=2, both drained entries target r3 (0xA0 then 0xB0):
  - port 0 rf_wr_en=0, port 1 writes 0xB0;
  - out_data=0xB0.
- Forwarding: queue holds r4=0x01 (older) and r4=0x02 (younger). fwd_addr=4 gives fwd_hit=1, fwd_data=0x02. fwd_addr=6 gives fwd_hit=0.
- Flush and async reset:
  - internal_reset with 3 entries queued: rf_wr_en=0 that cycle; count=0 and out_valid=0 next cycle; no later writes occur.
  - rst_n pulsed low mid-stream: all outputs go to zero asynchronously.

Source files
------------

// File: rtl/wb_queue_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : wb_pkg
//  Description: Shared types and sizing helpers for the multi-lane
//               write-back queue.
//  Revision   : 1.0 - initial release
// ============================================================================
package wb_pkg;

   localparam int WB_AW = 3;
   localparam int WB_DW = 8;

   // One pending register-file write at the package's default widths.
   typedef struct packed {
      logic [WB_AW-1:0] dst;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

   // Pointer width for a DEPTH-entry ring; keeps at least one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy counter width, wide enough to hold DEPTH itself.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Slot offset of a lane within the compacted enqueue group: the number of
   // accepted lanes older than it.
   function automatic int lane_slot(input logic [31:0] mask, input int lane);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         if ((i < lane) && mask[i]) n++;
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_queue_multi_fwd_cam.sv
`default_nettype none
// ============================================================================
//  Module     : wb_fwd_cam
//  Description: Forwarding lookup across the valid queue entries; the
//               youngest entry whose destination matches wins.
//  Revision   : 1.0 - initial release
// ============================================================================
module wb_fwd_cam
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 8,
   parameter int AW    = 3,
   parameter int PW    = ptr_width(DEPTH),
   parameter int CW    = cnt_width(DEPTH)
) (
   input  logic [AW-1:0] ent_dst  [DEPTH],
   input  logic [DW-1:0] ent_data [DEPTH],
   input  logic [PW-1:0] rd_ptr,
   input  logic [CW-1:0] count,
   input  logic [AW-1:0] addr,
   output logic          hit,
   output logic [DW-1:0] data
);

   logic [PW-1:0] idx;

   // Walk oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if ((CW'(i) < count) && (ent_dst[idx] == addr)) begin
            hit  = 1'b1;
            data = ent_data[idx];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_queue_multi.sv
`default_nettype none
// ============================================================================
//  Module     : wb_queue_multi
//  Description: Multi-lane write-back stage. Compacts up to LANES results per
//               cycle into an in-order queue, retires up to WPORTS per cycle
//               to the register file, forwards pending data and reports the
//               youngest retired write on a registered output channel.
//  Revision   : 1.0 - initial release
// ============================================================================
module wb_queue_multi
   import wb_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int WPORTS = 1,
   parameter int DEPTH  = 4,
   parameter int DW     = WB_DW,
   parameter int AW     = WB_AW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 internal_reset,
   input  logic [LANES-1:0]     ex_valid,
   input  logic [LANES-1:0]     ex_wr_en,
   input  logic [LANES*AW-1:0]  ex_dst,
   input  logic [LANES*DW-1:0]  ex_data,
   output logic                 stall,
   output logic [WPORTS-1:0]    rf_wr_en,
   output logic [WPORTS*AW-1:0] rf_dst,
   output logic [WPORTS*DW-1:0] rf_data,
   input  logic [AW-1:0]        fwd_addr,
   output logic                 fwd_hit,
   output logic [DW-1:0]        fwd_data,
   output logic                 out_valid,
   output logic [AW-1:0]        out_dst,
   output logic [DW-1:0]        out_data
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [AW-1:0]     mem_dst  [DEPTH];
   logic [DW-1:0]     mem_data [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic [LANES-1:0]  take;
   logic [CW-1:0]     enq_cnt;
   logic [CW-1:0]     drain_cnt;
   logic [WPORTS-1:0] port_live;
   logic [WPORTS-1:0] wr_en;
   logic [PW-1:0]     port_idx [WPORTS];
   logic [AW-1:0]     sel_dst;
   logic [DW-1:0]     sel_data;

   // Back-pressure depends only on the registered occupancy.
   assign stall = (CW'(DEPTH) - count) < CW'(LANES);

   // Accepted lanes: valid, writing, not stalled and not being flushed.
   always_comb begin
      take    = '0;
      enq_cnt = '0;
      for (int l = 0; l < LANES; l++) begin
         take[l] = ex_valid[l] & ex_wr_en[l] & ~stall & ~internal_reset;
         enq_cnt = enq_cnt + CW'(take[l]);
      end
   end

   // Drain selection, same-destination suppression and youngest-write pick.
   always_comb begin
      drain_cnt = '0;
      port_live = '0;
      wr_en     = '0;
      sel_dst   = '0;
      sel_data  = '0;
      for (int p = 0; p < WPORTS; p++) begin
         port_idx[p]  = rd_ptr + PW'(p);
         port_live[p] = (CW'(p) < count) & ~internal_reset;
         if (port_live[p]) drain_cnt = drain_cnt + CW'(1);
      end
      for (int p = 0; p < WPORTS; p++) begin
         wr_en[p] = port_live[p];
         for (int q = p + 1; q < WPORTS; q++) begin
            if (port_live[q] && (mem_dst[port_idx[q]] == mem_dst[port_idx[p]]))
               wr_en[p] = 1'b0;
         end
      end
      for (int p = 0; p < WPORTS; p++) begin
         if (wr_en[p]) begin
            sel_dst  = mem_dst[port_idx[p]];
            sel_data = mem_data[port_idx[p]];
         end
      end
   end

   assign rf_wr_en = wr_en;

   for (genvar p = 0; p < WPORTS; p++) begin : g_port
      assign rf_dst[p*AW +: AW]  = mem_dst[port_idx[p]];
      assign rf_data[p*DW +: DW] = mem_data[port_idx[p]];
   end

   // Queue storage: accepted lanes land compacted from the write pointer.
   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (take[l]) begin
            mem_dst[wr_ptr + PW'(lane_slot(32'(take), l))]  <= ex_dst[l*AW +: AW];
            mem_data[wr_ptr + PW'(lane_slot(32'(take), l))] <= ex_data[l*DW +: DW];
         end
      end
   end

   // Pointers and occupancy; a flush discards everything at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (internal_reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PW'(drain_cnt);
         wr_ptr <= wr_ptr + PW'(enq_cnt);
         count  <= count - drain_cnt + enq_cnt;
      end
   end

   // Registered output channel reporting the youngest retired write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_dst   <= '0;
         out_data  <= '0;
      end else if (internal_reset) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= |wr_en;
         if (|wr_en) begin
            out_dst  <= sel_dst;
            out_data <= sel_data;
         end
      end
   end

   wb_fwd_cam #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .AW    (AW),
      .PW    (PW),
      .CW    (CW)
   ) u_fwd_cam (
      .ent_dst  (mem_dst),
      .ent_data (mem_data),
      .rd_ptr   (rd_ptr),
      .count    (count),
      .addr     (fwd_addr),
      .hit      (fwd_hit),
      .data     (fwd_data)
   );

endmodule
`default_nettype wire
